// File: rtl/run_monitor_if.sv
// Data-memory read port and dump stream of the run monitor.
// The master side is the monitor, the slave side is the memory plus dump consumer.
interface run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_index;
    logic              dump_last;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output dump_valid, dump_data, dump_index, dump_last,
        input  dump_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  dump_valid, dump_data, dump_index, dump_last,
        output dump_ready
    );
endinterface

// File: rtl/run_monitor.sv
// Run controller for the pipelined MIPS core: holds the core in reset, counts the run,
// stops on END_PC or a cycle limit, then streams a window of data memory out.
module run_monitor #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 32,
    parameter int                RESET_CYCLES = 2,
    parameter logic [ADDR_W-1:0] END_PC       = 32'h30,
    parameter int                MAX_CYCLES   = 100000,
    parameter int                DUMP_BASE    = 12,
    parameter int                DUMP_WORDS   = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              core_reset,
    output logic              core_freeze,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  pc_change_count,
    run_monitor_if.master     bus
);
    typedef enum logic [2:0] {S_RESET, S_RUN, S_ISSUE, S_CAPTURE, S_HOLD, S_DONE} state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LAST_RUN  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [31:0]       RST_LOAD  = 32'(RESET_CYCLES);

    state_t            state_r, next_state_s;
    logic [31:0]       rst_cnt_r;
    logic [ADDR_W-1:0] prev_pc_r;
    logic [ADDR_W-1:0] idx_r, idx_next_s;
    logic              end_hit_s, limit_hit_s, handshake_s;

    // Next-state decode; END_PC takes priority over the cycle limit
    always_comb begin
        next_state_s = state_r;
        end_hit_s    = 1'b0;
        limit_hit_s  = 1'b0;
        handshake_s  = 1'b0;
        case (state_r)
            S_RESET: begin
                if (rst_cnt_r == 32'd1) next_state_s = S_RUN;
                else                    next_state_s = S_RESET;
            end
            S_RUN: begin
                end_hit_s   = (pc == END_PC);
                limit_hit_s = (cycle_count == LAST_RUN);
                if (end_hit_s || limit_hit_s) begin
                    if (DUMP_WORDS == 0) next_state_s = S_DONE;
                    else                 next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_ISSUE:   next_state_s = S_CAPTURE;
            S_CAPTURE: next_state_s = S_HOLD;
            S_HOLD: begin
                // dump_valid is always high in HOLD, so ready alone completes the handshake
                handshake_s = bus.dump_ready;
                if (handshake_s && bus.dump_last) next_state_s = S_DONE;
                else if (handshake_s)             next_state_s = S_ISSUE;
                else                              next_state_s = S_HOLD;
            end
            S_DONE:  next_state_s = S_DONE;
            default: next_state_s = S_RESET;
        endcase
    end

    // Window offset advances only on a non-final handshake
    always_comb begin
        idx_next_s = idx_r;
        if (handshake_s && !bus.dump_last) idx_next_s = idx_r + ADDR_ONE;
        else                               idx_next_s = idx_r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_RESET;
        else       state_r <= next_state_s;
    end

    // Reset countdown, run counters and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_r       <= RST_LOAD;
            prev_pc_r       <= ADDR_ZERO;
            cycle_count     <= CNT_ZERO;
            pc_change_count <= CNT_ZERO;
            timeout         <= 1'b0;
            core_reset      <= 1'b1;
            core_freeze     <= 1'b0;
            done            <= 1'b0;
        end else begin
            if (state_r == S_RESET && rst_cnt_r != 32'd0) rst_cnt_r <= rst_cnt_r - 32'd1;
            if (state_r == S_RUN) begin
                if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
                if (pc != prev_pc_r && pc_change_count != CNT_MAX)
                    pc_change_count <= pc_change_count + CNT_ONE;
                prev_pc_r <= pc;
                if (limit_hit_s && !end_hit_s) timeout <= 1'b1;
            end
            core_reset  <= (next_state_s == S_RESET);
            core_freeze <= (next_state_s == S_ISSUE) || (next_state_s == S_CAPTURE) ||
                           (next_state_s == S_HOLD)  || (next_state_s == S_DONE);
            done        <= (next_state_s == S_DONE);
        end
    end

    // Memory read strobe and the dump word registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r           <= ADDR_ZERO;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= ADDR_ZERO;
            bus.dump_valid  <= 1'b0;
            bus.dump_data   <= DATA_ZERO;
            bus.dump_index  <= ADDR_ZERO;
            bus.dump_last   <= 1'b0;
        end else begin
            idx_r         <= idx_next_s;
            bus.mem_rd_en <= (next_state_s == S_ISSUE);
            if (next_state_s == S_ISSUE) bus.mem_rd_addr <= BASE_A + idx_next_s;
            if (state_r == S_CAPTURE) begin
                bus.dump_data  <= bus.mem_rd_data;
                bus.dump_valid <= 1'b1;
                bus.dump_index <= idx_r;
                bus.dump_last  <= (idx_r == LAST_IDX);
            end else if (handshake_s) begin
                bus.dump_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: four configurations run side by side against a per-instance
// behavioural model, plus literal expectations for the end-of-run and dump scenarios.
module tb_run_monitor;
    localparam int          RC   = 2;
    localparam int          BASE = 12;
    localparam logic [31:0] ENDP = 32'h30;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    int          checks;
    int          failures;
    int          pass_num;
    logic [31:0] exp_w [4];
    logic [31:0] exp_a [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Instance 0 defaults, 1 timeout at 5, 2 limit coinciding with END_PC, 3 empty window
    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int MAXC = (g == 1) ? 5 : ((g == 2) ? 13 : 100000);
        localparam int DW   = (g == 0) ? 96 : ((g == 3) ? 0 : 4);

        logic        core_reset, core_freeze, done, timeout;
        logic [31:0] cycle_count, pc_change_count;
        run_monitor_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        run_monitor #(.MAX_CYCLES(MAXC), .DUMP_WORDS(DW)) dut (
            .clk(clk), .reset(reset), .pc(pc),
            .core_reset(core_reset), .core_freeze(core_freeze), .done(done),
            .timeout(timeout), .cycle_count(cycle_count),
            .pc_change_count(pc_change_count), .bus(bus)
        );

        int          hold_left, word, ph, held, cap;
        bit          armed, ended, to, dumping;
        logic [31:0] run_c, chg, prev, e_addr, e_data, e_index;
        logic [31:0] q_data[$];
        logic [31:0] q_addr[$];
        bit          q_last[$];

        // Memory: word[a] = 3*a, valid only in the cycle after the strobe
        always @(posedge clk) begin
            if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_rd_addr * 32'd3;
            else               bus.mem_rd_data <= 32'hDEAD_BEEF;
        end

        // Consumer: in the first pass word 1 is refused for four cycles
        initial begin
            bus.dump_ready = 1'b1;
            held = 0;
            forever begin
                @(negedge clk);
                if (pass_num == 1 && bus.dump_valid && bus.dump_index == 32'd1) begin
                    held++;
                    bus.dump_ready = (held > 4);
                end else begin
                    bus.dump_ready = 1'b1;
                end
            end
        end

        // Model: phases tracked as counters (reset hold, run, words delivered, cycle in word)
        initial forever begin
            @(posedge clk);
            if (reset) begin
                armed = 1'b1; hold_left = RC; ended = 1'b0; to = 1'b0;
                run_c = 32'd0; chg = 32'd0; prev = 32'd0; word = 0; ph = 0;
                q_data.delete(); q_addr.delete(); q_last.delete();
            end else begin
                if (bus.dump_valid && bus.dump_ready) begin
                    q_data.push_back(bus.dump_data);
                    q_last.push_back(bus.dump_last);
                end
                if (bus.mem_rd_en) q_addr.push_back(bus.mem_rd_addr);
                if (hold_left > 0) begin
                    hold_left--;
                end else if (!ended) begin
                    if (run_c != 32'hFFFF_FFFF) run_c++;
                    if (pc != prev && chg != 32'hFFFF_FFFF) chg++;
                    prev = pc;
                    if (pc == ENDP) ended = 1'b1;
                    else if (run_c == MAXC) begin ended = 1'b1; to = 1'b1; end
                end else if (word < DW) begin
                    if (ph < 2) ph++;
                    else if (bus.dump_ready) begin word++; ph = 0; end
                end
            end
        end

        // Compare every cycle once the model has seen a reset
        initial forever begin
            @(negedge clk);
            if (armed) begin
                dumping = ended && (word < DW);
                cap     = word + ((dumping && ph == 2) ? 1 : 0);
                e_addr  = (ended && DW > 0) ? 32'(BASE + ((word < DW) ? word : DW - 1)) : 32'd0;
                e_index = (cap > 0) ? 32'(cap - 1) : 32'd0;
                e_data  = (cap > 0) ? 32'((BASE + cap - 1) * 3) : 32'd0;
                check($sformatf("i%0d.core_reset", g), core_reset, hold_left > 0);
                check($sformatf("i%0d.core_freeze", g), core_freeze, ended);
                check($sformatf("i%0d.done", g), done, ended && word >= DW);
                check($sformatf("i%0d.timeout", g), timeout, to);
                check($sformatf("i%0d.cycle_count", g), cycle_count, run_c);
                check($sformatf("i%0d.pc_change_count", g), pc_change_count, chg);
                check($sformatf("i%0d.mem_rd_en", g), bus.mem_rd_en, dumping && ph == 0);
                check($sformatf("i%0d.mem_rd_addr", g), bus.mem_rd_addr, e_addr);
                check($sformatf("i%0d.dump_valid", g), bus.dump_valid, dumping && ph == 2);
                check($sformatf("i%0d.dump_data", g), bus.dump_data, e_data);
                check($sformatf("i%0d.dump_index", g), bus.dump_index, e_index);
                check($sformatf("i%0d.dump_last", g), bus.dump_last, cap > 0 && cap == DW);
            end
        end
    end

    initial begin
        logic ok;
        checks = 0; failures = 0; pass_num = 1;
        exp_w[0] = 32'd36; exp_w[1] = 32'd39; exp_w[2] = 32'd42; exp_w[3] = 32'd45;
        exp_a[0] = 32'd12; exp_a[1] = 32'd13; exp_a[2] = 32'd14; exp_a[3] = 32'd15;
        reset = 1'b1; pc = 32'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("lit_core_reset_held", gi[0].core_reset, 1'b1);

        // Pass 1: pc = 4k; stops when instance 1 shows word 2 so reset hits mid-window
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) check("lit_core_reset_released", gi[0].core_reset, 1'b0);
            pc = 32'(4 * k);
            if (gi[1].bus.dump_valid && gi[1].bus.dump_index == 32'd2) begin ok = 1'b1; break; end
        end
        check("lit_pass1_reached_word2", ok, 1'b1);
        check("lit_i0_cycles", gi[0].cycle_count, 32'd13);
        check("lit_i0_changes", gi[0].pc_change_count, 32'd12);
        check("lit_i0_timeout", gi[0].timeout, 1'b0);
        check("lit_i1_cycles", gi[1].cycle_count, 32'd5);
        check("lit_i1_changes", gi[1].pc_change_count, 32'd4);
        check("lit_i1_timeout", gi[1].timeout, 1'b1);
        check("lit_i2_cycles", gi[2].cycle_count, 32'd13);
        check("lit_i2_timeout", gi[2].timeout, 1'b0);
        check("lit_i3_done", gi[3].done, 1'b1);
        check("lit_i3_no_reads", gi[3].q_addr.size(), 32'd0);
        check("lit_i1_hold_cycles", gi[1].held, 32'd5);
        check("lit_i1_pass1_words", gi[1].q_data.size(), 32'd2);
        check("lit_i1_pass1_reads", gi[1].q_addr.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lit_i1_pass1_addr%0d", i),
                  (i < gi[1].q_addr.size()) ? gi[1].q_addr[i] : 32'hFFFF_FFFF, exp_a[i]);
        end

        // One-cycle reset pulse while a word is pending
        reset = 1'b1;
        @(negedge clk);
        check("lit_rst_dump_valid", gi[1].bus.dump_valid, 1'b0);
        check("lit_rst_core_reset", gi[1].core_reset, 1'b1);
        check("lit_rst_cycles", gi[1].cycle_count, 32'd0);
        check("lit_rst_done", gi[1].done, 1'b0);
        check("lit_rst_i0_changes", gi[0].pc_change_count, 32'd0);
        reset = 1'b0; pass_num = 2;
        @(negedge clk);

        // Pass 2: pc = 4*(k/2), every value held for two cycles
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            pc = 32'(4 * (k / 2));
            if (gi[0].done && gi[1].done && gi[2].done && gi[3].done) begin ok = 1'b1; break; end
        end
        check("lit_pass2_all_done", ok, 1'b1);
        check("lit_p2_i0_cycles", gi[0].cycle_count, 32'd25);
        check("lit_p2_i0_changes", gi[0].pc_change_count, 32'd12);
        check("lit_p2_i0_words", gi[0].q_data.size(), 32'd96);
        check("lit_p2_i1_changes", gi[1].pc_change_count, 32'd2);
        check("lit_p2_i2_cycles", gi[2].cycle_count, 32'd13);
        check("lit_p2_i2_changes", gi[2].pc_change_count, 32'd6);
        check("lit_p2_i2_timeout", gi[2].timeout, 1'b1);
        check("lit_p2_i1_words", gi[1].q_data.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lit_p2_i1_word%0d", i),
                  (i < gi[1].q_data.size()) ? gi[1].q_data[i] : 32'hFFFF_FFFF, exp_w[i]);
            check($sformatf("lit_p2_i1_last%0d", i),
                  (i < gi[1].q_last.size()) ? gi[1].q_last[i] : 1'bx, i == 3);
            check($sformatf("lit_p2_i1_addr%0d", i),
                  (i < gi[1].q_addr.size()) ? gi[1].q_addr[i] : 32'hFFFF_FFFF, exp_a[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller for the pipelined MIPS core. Replaces bench-side reset sequencing, end-PC detection and data-memory dump with a parametrised block.
- Holds the core in reset for a programmable number of cycles, then releases it.
- Counts cycles and PC changes, and stops the run on an end-PC match or a cycle timeout.
- Reads a window of data memory and streams it out over a valid/ready port.

Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, data memory word width
- CNT_W, 32, width of the cycle and PC-change counters
- RESET_CYCLES, 2, cycles core_reset is held after reset deasserts (must be ≥1)
- END_PC, 32'h30, PC value that ends the run
- MAX_CYCLES, 100000, number of RUN cycles before timeout (must be ≥1)
- DUMP_BASE, 12, first word address of the dump window
- DUMP_WORDS, 96, number of words to dump (0 is allowed)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- pc  in  ADDR_W  current core PC
- core_reset  out  1  reset to the core
- core_freeze  out  1  stall request to the core while dumping or done
- mem_rd_en  out  1  data memory read strobe
- mem_rd_addr  out  ADDR_W  word address for the read
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts the dump word
- dump_data  out  DATA_W  dumped word
- dump_index  out  ADDR_W  offset of the word within the window (0-based)
- dump_last  out  1  set with the final word of the window
- done  out  1  run and dump complete (sticky until reset)
- timeout  out  1  run ended by MAX_CYCLES rather than END_PC (sticky)
- cycle_count  out  CNT_W  RUN cycles elapsed; saturates at all-ones
- pc_change_count  out  CNT_W  RUN cycles where pc differed from the previous cycle's pc; saturates

Behaviour:
- Reset values (the cycle after reset is sampled high):
  - state=S_RESET, core_reset=1, core_freeze=0
  - mem_rd_en=0, mem_rd_addr=0
  - dump_valid=0, dump_data=0, dump_index=0, dump_last=0
  - done=0, timeout=0, both counters=0, internal prev_pc=0
- S_RESET:
  - core_reset=1; a countdown loads RESET_CYCLES.
  - After exactly RESET_CYCLES cycles with reset low, go to S_RUN; core_reset is 0 from the first S_RUN cycle.
- S_RUN:
  - Each cycle: cycle_count+=1 (saturating); if pc!=prev_pc then pc_change_count+=1; prev_pc<=pc.
  - pc==END_PC → S_DUMP, timeout stays 0.
  - Else, if the cycle about to be counted is the MAX_CYCLES-th → timeout<=1, go to S_DUMP.
  - If both occur in the same cycle, END_PC wins: timeout=0.
  - The terminating cycle is counted.
- S_DUMP:
  - core_freeze=1, core_reset=0, counters frozen.
  - Sub-state ISSUE: mem_rd_en=1 for exactly one cycle; mem_rd_addr=DUMP_BASE+idx, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - Sub-state CAPTURE (next cycle): register mem_rd_data into dump_data; dump_valid<=1; dump_index=idx; dump_last=(idx==DUMP_WORDS-1).
  - Sub-state HOLD: dump_data, dump_index and dump_last are stable while dump_valid=1 and dump_ready=0.
  - Handshake = dump_valid & dump_ready on a posedge. On handshake, dump_valid<=0. If last → S_DONE, else idx+=1 → ISSUE.
  - At most one read is outstanding. Best-case throughput is 1 word per 3 cycles.
  - DUMP_WORDS==0: go straight to S_DONE, no reads issued.
- S_DONE:
  - done=1, core_freeze=1, no reads, dump_valid=0.
  - Stays in S_DONE until reset.
- reset mid-operation: any state → S_RESET with all reset values. An in-flight read is discarded and a pending dump word is dropped without a handshake.
- dump_ready is ignored when dump_valid=0.
- pc is sampled only in S_RUN.

Test Plan:
- Defaults, pc steps 0,4,8,…,0x30 one per cycle from the first RUN cycle:
  - core_reset high for 2 cycles after reset falls.
  - End at pc=0x30: cycle_count=13, pc_change_count=12, timeout=0.
  - Dump then runs.
- MAX_CYCLES=5, pc never reaches END_PC:
  - Run stops after 5 RUN cycles, cycle_count=5, timeout=1.
  - Dump still runs; done=1 afterwards.
- DUMP_BASE=12, DUMP_WORDS=4, memory model word[a]=a*3, dump_ready=1:
  - Reads at addresses 12,13,14,15.
  - Outputs 36,39,42,45 with dump_index 0..3; dump_last only on 45.
- Same setup, dump_ready low for 4 cycles on word 1:
  - dump_data=39 and dump_index=1 held stable.
  - No extra mem_rd_en pulse while held.
  - Word 2 is issued only after the handshake.
- MAX_CYCLES=13 with pc reaching 0x30 on cycle 13:
  - END_PC wins: timeout=0, cycle_count=13.
- reset pulsed for 1 cycle while dump_valid=1 mid-window:
  - Next cycle dump_valid=0, core_reset=1, counters=0, done=0.
  - The full sequence replays and the dump restarts at index 0.
